// File: rtl/axi_trace_event_recorder.sv
// Timestamped multi-channel handshake recorder: one FIFO per channel, drained
// round-robin into a single registered output slot, with sticky overflow reporting.
module axi_trace_event_recorder #(
    parameter int unsigned NCH   = 5,
    parameter int unsigned DATAW = 64,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TSW   = 32,
    parameter int unsigned CIDW  = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int unsigned RECW  = TSW + CIDW + DATAW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       en_mask,
    input  logic [NCH-1:0]       ch_valid,
    input  logic [NCH-1:0]       ch_ready,
    input  logic [NCH*DATAW-1:0] ch_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RECW-1:0]      out_data,
    output logic [NCH-1:0]       ovf,
    output logic [15:0]          drop_cnt,
    input  logic                 ovf_clr
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned ENTW = TSW + DATAW;

    logic [TSW-1:0]  ts;
    logic [ENTW-1:0] mem [NCH][DEPTH];
    logic [AW:0]     wr_ptr [NCH];
    logic [AW:0]     rd_ptr [NCH];
    logic [NCH-1:0]  fire, full, nonempty, push, drop;
    logic [CIDW-1:0] rr_start, rr_idx, grant;
    logic            grant_found, load;
    logic [ENTW-1:0] head;
    logic [4:0]      drop_num;
    logic [16:0]     drop_sum;

    // Fullness is taken before the edge, so a pop in the same cycle never rescues a push.
    always_comb begin
        fire     = ch_valid & ch_ready & en_mask;
        full     = '0;
        nonempty = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            full[i]     = (wr_ptr[i] - rd_ptr[i]) == (AW+1)'(DEPTH);
            nonempty[i] = wr_ptr[i] != rd_ptr[i];
        end
        push = fire & ~full;
        drop = fire & full;
    end

    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        rr_idx      = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            rr_idx = CIDW'((32'(rr_start) + k) % NCH);
            if (!grant_found && nonempty[rr_idx]) begin
                grant       = rr_idx;
                grant_found = 1'b1;
            end
        end
    end

    assign load = grant_found && (!out_valid || out_ready);
    assign head = mem[grant][rd_ptr[grant][AW-1:0]];

    always_comb begin
        drop_num = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            drop_num = drop_num + 5'(drop[i]);
        end
        drop_sum = (ovf_clr ? 17'd0 : {1'b0, drop_cnt}) + 17'(drop_num);
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NCH; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i][AW-1:0]] <= {ts, ch_data[i*DATAW +: DATAW]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ovf       <= '0;
            drop_cnt  <= '0;
            rr_start  <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            ts <= ts + TSW'(1);
            for (int unsigned i = 0; i < NCH; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + (AW+1)'(1);
                end
            end
            if (load) begin
                rd_ptr[grant] <= rd_ptr[grant] + (AW+1)'(1);
                out_valid     <= 1'b1;
                out_data      <= {head[ENTW-1 -: TSW], grant, head[DATAW-1:0]};
                rr_start      <= (grant == CIDW'(NCH-1)) ? '0 : grant + CIDW'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Clear is applied first so same-cycle drops still register.
            ovf      <= (ovf_clr ? '0 : ovf) | drop;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
endmodule

// File: tb/tb_axi_trace_event_recorder.sv
// Bench for axi_trace_event_recorder: directed vector table, corner-case sequences,
// and randomized traffic checked every cycle against a queue-based reference model.
module tb_axi_trace_event_recorder;
    localparam int NCH   = 5;
    localparam int DATAW = 16;
    localparam int DEPTH = 8;
    localparam int TSW   = 4;
    localparam int CIDW  = 3;
    localparam int RECW  = TSW + CIDW + DATAW;

    logic                 clk = 1'b0;
    logic                 rst, out_ready, ovf_clr, out_valid;
    logic [NCH-1:0]       en_mask, ch_valid, ch_ready, ovf;
    logic [NCH*DATAW-1:0] ch_data;
    logic [RECW-1:0]      out_data;
    logic [15:0]          drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    axi_trace_event_recorder #(
        .NCH(NCH), .DATAW(DATAW), .DEPTH(DEPTH), .TSW(TSW)
    ) dut (
        .clk(clk), .rst(rst), .en_mask(en_mask), .ch_valid(ch_valid),
        .ch_ready(ch_ready), .ch_data(ch_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .ovf(ovf),
        .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: per-channel queues plus one record slot; state after the last edge.
    typedef logic [TSW+DATAW-1:0] ent_t;
    ent_t           mq [NCH][$];
    logic           m_valid = 1'b0;
    logic [RECW-1:0] m_data = '0;
    logic [NCH-1:0] m_ovf = '0;
    logic [15:0]    m_drop = '0;
    logic [TSW-1:0] m_ts = '0;
    int             m_start = 0;
    bit             model_on = 1'b0;

    always @(negedge clk) begin
        int   g;
        ent_t e;
        bit   ev [NCH];
        bit   was_full [NCH];
        if (model_on) begin
            check("out_valid", out_valid, m_valid);
            if (m_valid) check("out_data", out_data, m_data);
            check("ovf", ovf, m_ovf);
            check("drop_cnt", drop_cnt, m_drop);
            if (rst) begin
                for (int i = 0; i < NCH; i++) mq[i].delete();
                m_valid = 1'b0; m_data = '0; m_ovf = '0; m_drop = '0; m_ts = '0; m_start = 0;
            end else begin
                g = -1;
                if (!m_valid || out_ready) begin
                    for (int k = 0; k < NCH; k++) begin
                        if (g < 0 && mq[(m_start + k) % NCH].size() > 0) g = (m_start + k) % NCH;
                    end
                end
                for (int i = 0; i < NCH; i++) begin
                    ev[i]       = ch_valid[i] && ch_ready[i] && en_mask[i];
                    was_full[i] = mq[i].size() == DEPTH;
                end
                if (g >= 0) begin
                    e       = mq[g].pop_front();
                    m_data  = {e[TSW+DATAW-1:DATAW], CIDW'(g), e[DATAW-1:0]};
                    m_valid = 1'b1;
                    m_start = (g + 1) % NCH;
                end else if (out_ready) begin
                    m_valid = 1'b0;
                end
                if (ovf_clr) begin
                    m_ovf  = '0;
                    m_drop = '0;
                end
                for (int i = 0; i < NCH; i++) begin
                    if (ev[i]) begin
                        if (was_full[i]) begin
                            m_ovf[i] = 1'b1;
                            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                        end else begin
                            mq[i].push_back({m_ts, ch_data[i*DATAW +: DATAW]});
                        end
                    end
                end
                m_ts = m_ts + TSW'(1);
            end
        end
    end

    typedef struct {
        logic [TSW-1:0]      ts_at;
        logic [NCH-1:0]      fire;
        logic [DATAW-1:0]    base;
        int                  n;
        logic [0:4][CIDW-1:0] order;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        int got, first_k, guard, xfers, n3, n0;
        logic [RECW-1:0] held;
        bit prev_stall;

        // Expected grant orders follow the round-robin rotation across consecutive vectors.
        vecs[0] = '{ts_at: 4'd4,  fire: 5'b10011, base: 16'h1000, n: 3, order: {3'd0, 3'd1, 3'd4, 3'd0, 3'd0}};
        vecs[1] = '{ts_at: 4'd10, fire: 5'b10011, base: 16'h2000, n: 3, order: {3'd0, 3'd1, 3'd4, 3'd0, 3'd0}};
        vecs[2] = '{ts_at: 4'd10, fire: 5'b00100, base: 16'h00A3, n: 1, order: {3'd2, 3'd0, 3'd0, 3'd0, 3'd0}};
        vecs[3] = '{ts_at: 4'd15, fire: 5'b11111, base: 16'h3000, n: 5, order: {3'd3, 3'd4, 3'd0, 3'd1, 3'd2}};
        vecs[4] = '{ts_at: 4'd0,  fire: 5'b00001, base: 16'h4000, n: 1, order: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
        vecs[5] = '{ts_at: 4'd7,  fire: 5'b01010, base: 16'h5000, n: 2, order: {3'd1, 3'd3, 3'd0, 3'd0, 3'd0}};

        rst = 1'b1; out_ready = 1'b0; ovf_clr = 1'b0;
        en_mask = '1; ch_valid = '0; ch_ready = '0; ch_data = '0;
        tick(); tick();
        model_on = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_ovf", ovf, '0);
        check("rst_drop_cnt", drop_cnt, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            out_ready = 1'b1;
            guard = 0;
            while (m_ts != vecs[v].ts_at && guard < 40) begin
                tick();
                guard++;
            end
            ch_valid = vecs[v].fire;
            ch_ready = vecs[v].fire;
            for (int c = 0; c < NCH; c++) ch_data[c*DATAW +: DATAW] = vecs[v].base + DATAW'(c);
            tick();
            ch_valid = '0; ch_ready = '0;
            got = 0; first_k = -1;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (out_valid) begin
                    if (first_k < 0) first_k = k;
                    if (got < vecs[v].n) begin
                        check("tbl_cid", out_data[DATAW +: CIDW], vecs[v].order[got]);
                        check("tbl_ts", out_data[RECW-1 -: TSW], vecs[v].ts_at);
                        check("tbl_data", out_data[DATAW-1:0], vecs[v].base + DATAW'(vecs[v].order[got]));
                    end
                    got++;
                end
                @(posedge clk); #1;
            end
            check("tbl_count", got, vecs[v].n);
            check("tbl_latency", first_k, 1);
        end

        // Overflow: park a ch1 record in the slot, then ten events on ch3.
        out_ready = 1'b0;
        ch_valid = 5'b00010; ch_ready = 5'b00010; ch_data[1*DATAW +: DATAW] = 16'h0111;
        tick();
        ch_valid = '0; ch_ready = '0;
        tick(); tick();
        for (int j = 0; j < 10; j++) begin
            ch_valid = 5'b01000; ch_ready = 5'b01000; ch_data[3*DATAW +: DATAW] = 16'h0300 + DATAW'(j);
            tick();
        end
        ch_valid = '0; ch_ready = '0;
        @(negedge clk);
        check("ovf_after_burst", ovf, 5'b01000);
        check("drop_after_burst", drop_cnt, 16'd2);
        @(posedge clk); #1;

        // Clear/set collision on ch0.
        for (int j = 0; j < 9; j++) begin
            ch_valid = 5'b00001; ch_ready = 5'b00001; ch_data[0 +: DATAW] = 16'h0A00 + DATAW'(j);
            ovf_clr = (j == 8);
            tick();
        end
        ch_valid = '0; ch_ready = '0; ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_clr_collision", ovf, 5'b00001);
        check("drop_clr_collision", drop_cnt, 16'd1);
        @(posedge clk); #1;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_clr_alone", ovf, '0);
        check("drop_clr_alone", drop_cnt, '0);
        @(posedge clk); #1;

        // Drain with out_ready pattern 1,0,0,1: stalled records must hold.
        xfers = 0; n3 = 0; n0 = 0; prev_stall = 1'b0; held = '0;
        for (int k = 0; k < 60; k++) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            @(negedge clk);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, held);
            end
            prev_stall = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                xfers++;
                if (out_data[DATAW +: CIDW] == 3'd3) begin
                    check("ch3_order", out_data[DATAW-1:0], 16'h0300 + DATAW'(n3));
                    n3++;
                end
                if (out_data[DATAW +: CIDW] == 3'd0) begin
                    check("ch0_order", out_data[DATAW-1:0], 16'h0A00 + DATAW'(n0));
                    n0++;
                end
            end
            @(posedge clk); #1;
        end
        check("drain_total", xfers, 17);
        check("drain_ch3", n3, 8);
        check("drain_ch0", n0, 8);

        // Reset while three records are buffered.
        out_ready = 1'b0;
        ch_valid = 5'b00111; ch_ready = 5'b00111;
        tick();
        ch_valid = '0; ch_ready = '0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_data", out_data, '0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("no_stale", out_valid, 1'b0);
            @(posedge clk); #1;
        end

        // Drop counter saturation with every channel dropping each cycle.
        out_ready = 1'b0;
        ch_valid = '1; ch_ready = '1;
        repeat (13120) tick();
        ch_valid = '0; ch_ready = '0;
        @(negedge clk);
        check("drop_saturated", drop_cnt, 16'hFFFF);
        check("ovf_all", ovf, 5'b11111);
        @(posedge clk); #1;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0; out_ready = 1'b1;
        repeat (50) tick();

        // Randomized traffic, checked by the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            en_mask   = NCH'($urandom) | NCH'($urandom);
            ch_valid  = NCH'($urandom);
            ch_ready  = NCH'($urandom);
            for (int c = 0; c < NCH; c++) ch_data[c*DATAW +: DATAW] = DATAW'($urandom);
            out_ready = (k < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            ovf_clr   = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; ovf_clr = 1'b0; ch_valid = '0; ch_ready = '0; out_ready = 1'b1;
        repeat (60) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_trace_event_recorder.md
# axi_trace_event_recorder

Captures completed valid/ready handshakes on up to NCH independent trace channels and turns them into timestamped records merged onto one output stream. Intended for AW/W/B/AR/R-style channel taps of the AXI trace monitors. Each channel has its own buffer, so bursts on one channel do not stall capture on the others. Records are drained round-robin to a trace sink or DMA writer, and per-channel overflow is reported.

## Interface
Parameters:
- NCH, 5: number of trace channels (1..16).
- DATAW, 64: payload width per channel; narrower channel payloads are zero-extended by the instantiator.
- DEPTH, 8: entries per channel FIFO; power of two, at least 2.
- TSW, 32: timestamp width.
- CIDW (derived), max(1, clog2(NCH)): channel index width.
- RECW (derived), TSW+CIDW+DATAW: record width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- en_mask, in, NCH: per-channel capture enable.
- ch_valid, in, NCH: observed VALID per channel.
- ch_ready, in, NCH: observed READY per channel. The block never drives the observed bus.
- ch_data, in, NCH*DATAW: payload; channel i occupies bits [i*DATAW +: DATAW].
- out_valid, out, 1: record available.
- out_ready, in, 1: sink accepts the record.
- out_data, out, RECW: {timestamp, channel index, payload}, timestamp in the MSBs.
- ovf, out, NCH: sticky per-channel overflow flags.
- drop_cnt, out, 16: total dropped events, saturating.
- ovf_clr, in, 1: clears ovf and drop_cnt.

## Operation
- Timestamp ts: a free-running TSW-bit counter. It is 0 in the first cycle after reset, increments every cycle, and wraps from 2^TSW-1 to 0.
- Event: channel i fires in a cycle when ch_valid[i] & ch_ready[i] & en_mask[i] at the rising edge. The block then pushes {ts, ch_data[i]} into FIFO i, where ts is the value in that cycle.
- Channels are captured in parallel. Any number of channels may fire in the same cycle with no loss, provided their FIFOs are not full.
- Full FIFO: fullness is evaluated before the edge. An event on a full FIFO is dropped, even if the same FIFO is popped in that cycle. A drop sets ovf[i] and increments drop_cnt, which saturates at 16'hFFFF.
- Multiple drops in one cycle add their count to drop_cnt, still saturating.
- ovf_clr: zeroes ovf and drop_cnt. If drops occur in the same cycle, ovf_clr is applied first and the new drops are then recorded (set wins; drop_cnt equals the new count).
- Output stage: a single registered record slot. It loads when it is empty or when out_valid & out_ready, provided at least one FIFO is non-empty.
- Arbitration: round-robin among non-empty FIFOs. The search starts at the channel after the last granted one; after reset the search starts at channel 0. Exactly one FIFO is popped per load.
- A record carries {ts of the event, i, payload}. Records from any one channel leave in capture order.
- Disabling en_mask[i] stops new captures only. Entries already buffered still drain.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, ovf = 0, drop_cnt = 0.
  - All FIFOs empty, ts = 0, round-robin pointer = channel 0.
- Reset mid-operation discards all buffered and in-flight records. Reset has priority over every other input.
- Latency: a handshake in cycle T gives out_valid in cycle T+2, provided the output slot is free and no other channel has priority.
- Throughput: one record per cycle while out_ready is held high and data is buffered.
- Output handshake: out_data is stable while out_valid & !out_ready. out_valid never drops without a transfer.
- A FIFO pop and a capture push on the same non-full FIFO in the same cycle both take effect; occupancy is unchanged.
- The output slot drains back-to-back with no bubble: a slot transfer and reload happen in the same cycle.

## Test plan
- Single event: NCH=5, one handshake on ch 2 with data 0xA5 at ts=10, out_ready=1 → exactly one record {ts=10, cid=2, data=0xA5}, out_valid in cycle T+2.
- Simultaneous events: channels 0, 1 and 4 fire in the same cycle at ts=20 → three records in order 0, 1, 4, all carrying ts=20; a second identical burst is output in order 0, 1, 4 again, following the round-robin rotation from last grant 4.
- Overflow: DEPTH=8, out_ready=0, 10 handshakes on ch 3 → 8 buffered, ovf=5'b01000, drop_cnt=2. Releasing out_ready then yields exactly 8 records in capture order.
- Backpressure: out_ready toggles 1,0,0,1 while records are pending → out_data is held constant across the stall, and no record is lost or duplicated.
- Clear/set collision: ovf_clr asserted in the same cycle as a drop on ch 0 → ovf=5'b00001, drop_cnt=1. ovf_clr alone the next cycle → both 0.
- Reset and wrap: TSW=4, reset asserted with 3 records buffered → out_valid=0 the next cycle and no stale records afterwards. Events at ts=15 then ts=0 are both stamped correctly across the wrap.
